// File: rtl/smart_home_pkg.sv
// Shared definitions for the smart_home keypad front end: key codes,
// the entry state machine encoding and the password width.
package smart_home_pkg;

  localparam int PW_W = 17;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
  localparam logic [3:0] KEY_CHG = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    WAIT_RESP,
    LOCKOUT
  } kp_state_t;

  // 99999 < 2^17, so the shifted-in decimal digit never overflows PW_W.
  function automatic logic [PW_W-1:0] acc_digit(input logic [PW_W-1:0] acc,
                                                input logic [3:0] digit);
    return acc * PW_W'(10) + PW_W'(digit);
  endfunction

endpackage

// File: rtl/kp_timer.sv
// Loadable down-counter shared by the entry timeout, response window and
// lockout; done fires on a ticking cycle once the count has reached zero.
module kp_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = tick && (count == '0);

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: assembles decimal passwords, issues unlock/change
// strobes per room, and tracks failed unlock attempts with a lockout.
module keypad_entry
  import smart_home_pkg::*;
#(
  parameter int DIGITS         = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int RESP_CYCLES    = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic [2:0]      room_sel,
  input  logic            unlock,
  output logic [PW_W-1:0] in_password,
  output logic [PW_W-1:0] change_password,
  output logic [7:0]      e_button,
  output logic [7:0]      rs_button,
  output logic            entry_err,
  output logic            locked_out,
  output logic [2:0]      digit_cnt
);

  localparam int MAX_AB = (TIMEOUT_CYCLES > RESP_CYCLES) ? TIMEOUT_CYCLES : RESP_CYCLES;
  localparam int MAX_C  = (LOCKOUT_CYCLES > MAX_AB) ? LOCKOUT_CYCLES : MAX_AB;
  localparam int TW     = $clog2(MAX_C + 1);
  localparam int TRW    = $clog2(MAX_TRIES + 1);

  localparam logic [TW-1:0]  TOUT_LD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  RESP_LD = TW'(RESP_CYCLES - 1);
  localparam logic [TW-1:0]  LOCK_LD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]     FULL    = 3'(DIGITS);
  localparam logic [TRW-1:0] LAST_TRY = TRW'(MAX_TRIES - 1);

  kp_state_t       state, state_next;
  logic [PW_W-1:0] acc, acc_next;
  logic [2:0]      cnt_next;
  logic [2:0]      room, room_next;
  logic            chg, chg_next;
  logic [TRW-1:0]  tries, tries_next;
  logic [PW_W-1:0] in_pw_next, chg_pw_next;
  logic [7:0]      e_next, rs_next;
  logic            err_next, lock_next;
  logic            t_load, t_tick, t_done;
  logic [TW-1:0]   t_val;
  logic            is_digit;

  kp_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .tick     (t_tick),
    .done     (t_done)
  );

  assign is_digit = (key_code <= 4'd9);

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    cnt_next    = digit_cnt;
    room_next   = room;
    chg_next    = chg;
    tries_next  = tries;
    in_pw_next  = in_password;
    chg_pw_next = change_password;
    e_next      = '0;
    rs_next     = '0;
    err_next    = 1'b0;
    lock_next   = locked_out;
    t_load      = 1'b0;
    t_val       = TOUT_LD;
    t_tick      = 1'b0;

    case (state)
      IDLE: begin
        if (key_valid && is_digit) begin
          acc_next   = PW_W'(key_code);
          cnt_next   = 3'd1;
          room_next  = room_sel;
          chg_next   = 1'b0;
          t_load     = 1'b1;
          state_next = ENTRY;
        end else if (key_valid && key_code == KEY_CHG) begin
          acc_next   = '0;
          cnt_next   = 3'd0;
          room_next  = room_sel;
          chg_next   = 1'b1;
          t_load     = 1'b1;
          state_next = ENTRY;
        end
      end

      ENTRY: begin
        if (key_valid) begin
          // Any key, even a dropped digit, restarts the idle timer.
          t_load = 1'b1;
          if (is_digit) begin
            if (digit_cnt < FULL) begin
              acc_next = acc_digit(acc, key_code);
              cnt_next = digit_cnt + 3'd1;
            end
          end else if (key_code == KEY_CLR) begin
            acc_next   = '0;
            cnt_next   = '0;
            chg_next   = 1'b0;
            state_next = IDLE;
          end else if (key_code == KEY_ENT) begin
            acc_next   = '0;
            cnt_next   = '0;
            chg_next   = 1'b0;
            state_next = IDLE;
            if (digit_cnt < FULL) begin
              err_next = 1'b1;
            end else if (chg) begin
              chg_pw_next = acc;
              rs_next     = 8'd1 << room;
            end else begin
              in_pw_next = acc;
              e_next     = 8'd1 << room;
              t_val      = RESP_LD;
              state_next = WAIT_RESP;
            end
          end
        end else begin
          t_tick = 1'b1;
          if (t_done) begin
            err_next   = 1'b1;
            acc_next   = '0;
            cnt_next   = '0;
            chg_next   = 1'b0;
            state_next = IDLE;
          end
        end
      end

      WAIT_RESP: begin
        t_tick = 1'b1;
        if (unlock) begin
          tries_next = '0;
          state_next = IDLE;
        end else if (t_done) begin
          if (tries == LAST_TRY) begin
            tries_next = '0;
            lock_next  = 1'b1;
            t_load     = 1'b1;
            t_val      = LOCK_LD;
            state_next = LOCKOUT;
          end else begin
            tries_next = tries + TRW'(1);
            state_next = IDLE;
          end
        end
      end

      LOCKOUT: begin
        t_tick = 1'b1;
        if (t_done) begin
          lock_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      acc             <= '0;
      digit_cnt       <= '0;
      room            <= '0;
      chg             <= 1'b0;
      tries           <= '0;
      in_password     <= '0;
      change_password <= '0;
      e_button        <= '0;
      rs_button       <= '0;
      entry_err       <= 1'b0;
      locked_out      <= 1'b0;
    end else begin
      state           <= state_next;
      acc             <= acc_next;
      digit_cnt       <= cnt_next;
      room            <= room_next;
      chg             <= chg_next;
      tries           <= tries_next;
      in_password     <= in_pw_next;
      change_password <= chg_pw_next;
      e_button        <= e_next;
      rs_button       <= rs_next;
      entry_err       <= err_next;
      locked_out      <= lock_next;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: expected strobes are queued as keys are
// issued and a monitor pops/compares whenever a strobe or error appears.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [2:0]  room_sel = 3'd0;
  logic        unlock = 1'b0;
  logic [16:0] in_password;
  logic [16:0] change_password;
  logic [7:0]  e_button;
  logic [7:0]  rs_button;
  logic        entry_err;
  logic        locked_out;
  logic [2:0]  digit_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 unlock strobe, 1 change strobe, 2 entry error
    logic [7:0]  btn;
    logic [16:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  keypad_entry dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .room_sel        (room_sel),
    .unlock          (unlock),
    .in_password     (in_password),
    .change_password (change_password),
    .e_button        (e_button),
    .rs_button       (rs_button),
    .entry_err       (entry_err),
    .locked_out      (locked_out),
    .digit_cnt       (digit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [2:0] room, input logic [16:0] val);
    exp_t e;
    e.kind = kind;
    e.btn  = (kind == 2) ? 8'd0 : (8'd1 << room);
    e.val  = val;
    sb.push_back(e);
  endtask

  // Called at a falling edge; key is sampled on the next rising edge.
  task automatic press(input logic [3:0] k, input logic [2:0] r);
    key_valid = 1'b1;
    key_code  = k;
    room_sel  = r;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_seq(input logic [3:0] ks[], input logic [2:0] r);
    foreach (ks[i]) press(ks[i], r);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (e_button != 0 || rs_button != 0 || entry_err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: e=%b rs=%b err=%b expected nothing",
                   e_button, rs_button, entry_err);
        end else begin
          e = sb.pop_front();
          case (e.kind)
            0: begin
              chk("e_button", e_button, e.btn);
              chk("e_rs_quiet", rs_button, 0);
              chk("in_password", in_password, e.val);
            end
            1: begin
              chk("rs_button", rs_button, e.btn);
              chk("rs_e_quiet", e_button, 0);
              chk("change_password", change_password, e.val);
            end
            default: begin
              chk("entry_err", entry_err, 1);
              chk("err_e_quiet", e_button, 0);
              chk("err_rs_quiet", rs_button, 0);
            end
          endcase
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_pw"}, in_password, 0);
    chk({tag, "_chg_pw"}, change_password, 0);
    chk({tag, "_e"}, e_button, 0);
    chk({tag, "_rs"}, rs_button, 0);
    chk({tag, "_err"}, entry_err, 0);
    chk({tag, "_lock"}, locked_out, 0);
    chk({tag, "_cnt"}, digit_cnt, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Room 1 unlock, success on first window cycle
    push(0, 3'd1, 17'd45675);
    press_seq('{4'd4, 4'd5, 4'd6, 4'd7, 4'd5}, 3'd1);
    chk("cnt_full", digit_cnt, 5);
    press(4'hB, 3'd1);
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;

    // Room 0 password change
    push(1, 3'd0, 17'd99999);
    press_seq('{4'hC, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'hB}, 3'd0);
    chk("in_pw_after_change", in_password, 45675);

    // Short entry
    push(2, 3'd0, 17'd0);
    press_seq('{4'd1, 4'd2, 4'hB}, 3'd0);
    chk("short_in_pw", in_password, 45675);
    chk("short_cnt", digit_cnt, 0);

    // Sixth digit dropped
    push(0, 3'd2, 17'd12345);
    press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 3'd2);
    chk("cnt_sat", digit_cnt, 5);
    press(4'hB, 3'd2);
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;

    // Unlock only on the last cycle of the response window still succeeds
    push(0, 3'd3, 17'd54321);
    press_seq('{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'hB}, 3'd3);
    repeat (3) @(negedge clk);
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;
    chk("late_unlock_lock", locked_out, 0);

    // Three failures -> lockout
    for (int a = 0; a < 3; a++) begin
      push(0, 3'd4, 17'd24680);
      press_seq('{4'd2, 4'd4, 4'd6, 4'd8, 4'd0, 4'hB}, 3'd4);
      repeat (3) @(negedge clk);
      chk("lock_pre", locked_out, 0);
      @(negedge clk);
      chk("lock_post", locked_out, (a == 2) ? 1 : 0);
    end
    press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hB}, 3'd4);
    chk("lock_cnt_ignored", digit_cnt, 0);
    repeat (5004 - 11) @(negedge clk);
    chk("lock_last", locked_out, 1);
    press(4'd7, 3'd0);
    chk("lock_end", locked_out, 0);
    chk("lock_end_key_ignored", digit_cnt, 0);

    // Inactivity timeout
    push(2, 3'd0, 17'd0);
    press(4'd7, 3'd0);
    repeat (999) @(negedge clk);
    chk("tout_pre_err", entry_err, 0);
    chk("tout_pre_cnt", digit_cnt, 1);
    @(negedge clk);
    chk("tout_err", entry_err, 1);
    chk("tout_cnt", digit_cnt, 0);

    // Key on the timeout cycle wins
    press(4'd7, 3'd0);
    repeat (999) @(negedge clk);
    press(4'd8, 3'd0);
    chk("tout_key_err", entry_err, 0);
    chk("tout_key_cnt", digit_cnt, 2);
    press(4'hA, 3'd0);
    chk("clear_cnt", digit_cnt, 0);
    chk("clear_err", entry_err, 0);

    // Reset mid-entry
    press_seq('{4'd1, 4'd2, 4'd3}, 3'd0);
    chk("mid_cnt", digit_cnt, 3);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_entry");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during WAIT_RESP
    push(0, 3'd5, 17'd12345);
    press_seq('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hB}, 3'd5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Back in IDLE after reset
    push(0, 3'd6, 17'd67890);
    press_seq('{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'hB}, 3'd6);
    unlock = 1'b1;
    @(negedge clk);
    unlock = 1'b0;
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
